pmp_boot: RTL
=============

# pmp_boot

Sequencer that programs the PMP unit's CSR file from a packed region table and, optionally, verifies every register by readback. It sits on the CSR master side of the PMP's CSR port, in place of or multiplexed with the core CSR path during boot. It drives `csr_pmp_in_type` and consumes `csr_pmp_out_type`, and reports busy/done/error to the boot controller.

## Interface
- `pmp_region`, default 8: number of PMP entries. Must be a multiple of 4.
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin sequence. Honoured only in IDLE.
- `cfg_data`  in  pmp_region*8: expected pmpcfg bytes. Entry i is in bits [8i+7:8i]. Layout is L,0,0,A[1:0],X,W,R.
- `addr_data`  in  pmp_region*32: pmpaddr values. Entry i is in bits [32i+31:32i].
- `csr_pmp_in`  out  csr_pmp_in_type: cwren/cwaddr/cwdata/crden/craddr to the PMP.
- `csr_pmp_out`  in  csr_pmp_out_type: crdata/cready from the PMP. Combinational, same-cycle response.
- `busy`  out  1: high from the cycle after start acceptance until done.
- `done`  out  1: one-cycle pulse at the end of the sequence.
- `error`  out  1: sticky until the next accepted start.
- `err_addr`  out  12: CSR address of the first failed readback. Valid while error=1.

## Operation
- States: IDLE, WADDR, WCFG, RADDR, RCFG, DONE. A single index counter `idx` is wide enough for pmp_region-1.
- IDLE with start=1: capture cfg_data/addr_data into shadow registers, clear error/err_addr, set idx=0, go to WADDR.
- WADDR: cwren=1, cwaddr=csr_pmpaddr0+idx, cwdata=shadow addr[idx]. After idx=pmp_region-1, reset idx=0 and go to WCFG.
- pmpaddr is always written before pmpcfg, so lock bits written by this sequence cannot block its own address writes.
- WCFG: cwren=1, cwaddr=csr_pmpcfg0+idx, cwdata={cfg[4idx+3],cfg[4idx+2],cfg[4idx+1],cfg[4idx]}. After idx=pmp_region/4-1, go to RADDR (verify build) or DONE.
- RADDR/RCFG: crden=1 with the same address order as the writes.
  - Expected value for pmpaddr is the full 32 bits.
  - Expected value for pmpcfg is each byte masked with 8'h9F.
  - A read fails on cready=0 or on a crdata mismatch.
- On a failed read: set error. Load err_addr only if error was 0, so the first failure wins. Verification continues to the last register.
- Readback mismatches arise from pre-existing lock bits (L=1), because the PMP silently drops those writes. This is the intended detection path.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- cwren and crden are never asserted in the same cycle. When idle, all csr_pmp_in fields are 0.
- start is ignored outside IDLE. start held high re-triggers only after returning to IDLE, i.e. one IDLE cycle minimum.

## Timing
- Reset values: state IDLE, idx 0, busy 0, done 0, error 0, err_addr 0, all csr_pmp_in fields 0.
- Shadow registers are not reset.
- start is sampled in cycle 0. The first write is in cycle 1.
- Writes occupy W = pmp_region + pmp_region/4 cycles. Reads occupy R = W cycles (verify build only).
- done is high in cycle 1+W+R (verify) or 1+W (no verify). For pmp_region=8 that is cycle 21 or cycle 11.
- error and err_addr update in the cycle after the failing read and are visible no later than the done cycle.
- Reset mid-sequence: return to IDLE next cycle and drop all outputs to reset values. The PMP keeps whatever was already written, and no done pulse is issued.

## Configuration
- `PMP_BOOT_VERIFY_EN` defined: RADDR/RCFG states, compare logic and err_addr are present.
- `PMP_BOOT_VERIFY_EN` undefined:
  - WCFG goes straight to DONE.
  - crden is tied 0; error and err_addr are tied 0.
  - csr_pmp_out is unused.

## Structure
- Shared package (wires/constants): the state enum `pmp_boot_state_type` and the cfg readback mask constant 8'h9F. Existing `csr_pmpcfg0`/`csr_pmpaddr0` are reused.
- One sub-module, `pmp_boot_verify`, holds the readback compare and the first-error capture. It is instantiated only under `PMP_BOOT_VERIFY_EN`.

## Test plan
- pmp_region=8, all entries unlocked. addr[i]=32'h1000_0000+i, cfg bytes 8'h0F. Start → 8 addr writes and 2 cfg writes of 32'h0F0F0F0F; readback passes; done in cycle 21; error=0.
- cfg byte 8'hFF for entry 3 → write carries 8'hFF; readback expects 8'h9F; no error.
- Pre-lock entry 2 (cfg 8'h80, addr 32'h0) before start with addr[2]=32'h55 → error=1, err_addr=csr_pmpaddr0+2. The run continues and done still fires in cycle 21.
- start pulsed again in cycle 5 of a run → ignored: same write sequence, single done pulse.
- reset asserted in cycle 4 → next cycle busy=0, cwren=0, no done; a fresh start then completes normally.
- Build without `PMP_BOOT_VERIFY_EN` → crden never asserted; done in cycle 11; error stays 0 even with a locked entry.

Source files
------------

// File: rtl/pmp_boot_pkg.sv
// Shared types and constants for the PMP boot programming sequencer.
// CSR port structs toward the PMP, state encoding, base CSR addresses and the cfg readback mask.
package pmp_boot_pkg;

   typedef logic [2:0] pmp_boot_state_type;

   localparam pmp_boot_state_type ST_IDLE  = 3'd0;
   localparam pmp_boot_state_type ST_WADDR = 3'd1;
   localparam pmp_boot_state_type ST_WCFG  = 3'd2;
   localparam pmp_boot_state_type ST_RADDR = 3'd3;
   localparam pmp_boot_state_type ST_RCFG  = 3'd4;
   localparam pmp_boot_state_type ST_DONE  = 3'd5;

   localparam logic [11:0] csr_pmpcfg0  = 12'h3A0;
   localparam logic [11:0] csr_pmpaddr0 = 12'h3B0;

   // Bits 6:5 of each pmpcfg byte are hardwired zero in the PMP.
   localparam logic [7:0] pmp_cfg_rd_mask = 8'h9F;

   typedef struct packed {
      logic        cwren;
      logic [11:0] cwaddr;
      logic [31:0] cwdata;
      logic        crden;
      logic [11:0] craddr;
   } csr_pmp_in_type;

   typedef struct packed {
      logic [31:0] crdata;
      logic        cready;
   } csr_pmp_out_type;

   function automatic logic [31:0] cfg_rd_expect(input logic [31:0] wr_word);
      return wr_word & {4{pmp_cfg_rd_mask}};
   endfunction

endpackage

// File: rtl/pmp_boot_verify.sv
// Readback comparator with sticky error and first-failure address capture.
// Error/err_addr update one cycle after the failing read; no backpressure (PMP answers same cycle).
module pmp_boot_verify
   import pmp_boot_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            rd_vld,
   input  logic [11:0]     rd_addr,
   input  logic [31:0]     rd_exp,
   input  csr_pmp_out_type csr_pmp_out,
   output logic            error,
   output logic [11:0]     err_addr
);

   logic        error_q, error_d;
   logic [11:0] err_addr_q, err_addr_d;
   logic        rd_fail;

   always_comb begin
      rd_fail    = rd_vld && (!csr_pmp_out.cready || (csr_pmp_out.crdata != rd_exp));
      error_d    = error_q | rd_fail;
      err_addr_d = err_addr_q;
      if (rd_fail && !error_q) begin
         err_addr_d = rd_addr;
      end
      if (clear) begin
         error_d    = 1'b0;
         err_addr_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else begin
         error_q    <= error_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign error    = error_q;
   assign err_addr = err_addr_q;

endmodule

// File: rtl/pmp_boot.sv
// Programs PMP pmpaddr then pmpcfg CSRs from a region table; readback verify when PMP_BOOT_VERIFY_EN.
// done at cycle 1+W(+R) after start, W=R=n+n/4; no backpressure, start ignored unless idle.
module pmp_boot
   import pmp_boot_pkg::*;
#(
   parameter int pmp_region = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [pmp_region*8-1:0]  cfg_data,
   input  logic [pmp_region*32-1:0] addr_data,
   output csr_pmp_in_type          csr_pmp_in,
   input  csr_pmp_out_type         csr_pmp_out,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [11:0]             err_addr
);

   localparam int IDX_W = (pmp_region > 1) ? $clog2(pmp_region) : 1;
   localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(pmp_region - 1);
   localparam logic [IDX_W-1:0] CFG_LAST  = IDX_W'(pmp_region / 4 - 1);

   pmp_boot_state_type       state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [pmp_region*8-1:0]  cfg_sh_q, cfg_sh_d;
   logic [pmp_region*32-1:0] addr_sh_q, addr_sh_d;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cfg_sh_d  = cfg_sh_q;
      addr_sh_d = addr_sh_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_sh_d  = cfg_data;
               addr_sh_d = addr_data;
               idx_d     = '0;
               state_d   = ST_WADDR;
            end
         end
         ST_WADDR: begin
            if (idx_q == ADDR_LAST) begin
               idx_d   = '0;
               state_d = ST_WCFG;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WCFG: begin
            if (idx_q == CFG_LAST) begin
               idx_d = '0;
`ifdef PMP_BOOT_VERIFY_EN
               state_d = ST_RADDR;
`else
               state_d = ST_DONE;
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
`ifdef PMP_BOOT_VERIFY_EN
         ST_RADDR: begin
            if (idx_q == ADDR_LAST) begin
               idx_d   = '0;
               state_d = ST_RCFG;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_RCFG: begin
            if (idx_q == CFG_LAST) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
`endif
         default: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Shadow copy of the table; only meaningful after a start is accepted.
   always_ff @(posedge clock) begin
      cfg_sh_q  <= cfg_sh_d;
      addr_sh_q <= addr_sh_d;
   end

   always_comb begin
      csr_pmp_in = '0;
      case (state_q)
         ST_WADDR: begin
            csr_pmp_in.cwren  = 1'b1;
            csr_pmp_in.cwaddr = csr_pmpaddr0 + 12'(idx_q);
            csr_pmp_in.cwdata = addr_sh_q[32*idx_q +: 32];
         end
         ST_WCFG: begin
            csr_pmp_in.cwren  = 1'b1;
            csr_pmp_in.cwaddr = csr_pmpcfg0 + 12'(idx_q);
            csr_pmp_in.cwdata = cfg_sh_q[32*idx_q +: 32];
         end
`ifdef PMP_BOOT_VERIFY_EN
         ST_RADDR: begin
            csr_pmp_in.crden  = 1'b1;
            csr_pmp_in.craddr = csr_pmpaddr0 + 12'(idx_q);
         end
         ST_RCFG: begin
            csr_pmp_in.crden  = 1'b1;
            csr_pmp_in.craddr = csr_pmpcfg0 + 12'(idx_q);
         end
`endif
         default: ;
      endcase
   end

   assign busy = (state_q == ST_WADDR) || (state_q == ST_WCFG) ||
                 (state_q == ST_RADDR) || (state_q == ST_RCFG);
   assign done = (state_q == ST_DONE);

`ifdef PMP_BOOT_VERIFY_EN
   logic        start_acc;
   logic [31:0] rd_exp;

   always_comb begin
      start_acc = (state_q == ST_IDLE) && start;
      rd_exp    = '0;
      if (state_q == ST_RADDR) begin
         rd_exp = addr_sh_q[32*idx_q +: 32];
      end else if (state_q == ST_RCFG) begin
         rd_exp = cfg_rd_expect(cfg_sh_q[32*idx_q +: 32]);
      end
   end

   pmp_boot_verify u_verify (
      .clock       (clock),
      .reset       (reset),
      .clear       (start_acc),
      .rd_vld      (csr_pmp_in.crden),
      .rd_addr     (csr_pmp_in.craddr),
      .rd_exp      (rd_exp),
      .csr_pmp_out (csr_pmp_out),
      .error       (error),
      .err_addr    (err_addr)
   );
`else
   logic unused_csr_pmp_out;
   assign unused_csr_pmp_out = ^csr_pmp_out;
   assign error    = 1'b0;
   assign err_addr = '0;
`endif

endmodule
